ball_mover: RTL and testbench

// Ball position engine: consumes per-axis direction bits (x_du/y_du) from the boundary/direction logic
// and owns the ball's x/y registers, stepping them once per frame tick. Each step runs an erase-old /

---
 rtl/ball_pkg.sv | 33 +++
 rtl/ball_mover_if.sv | 20 ++
 rtl/ball_mover_tick_divider.sv | 23 ++
 rtl/ball_mover.sv | 106 ++++++++++
 tb/tb_ball_mover.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ball_pkg.sv
// Shared types and step arithmetic for the ball position engine.
package ball_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    MOVE  = 2'd2,
    DRAW  = 2'd3
  } state_t;

  // One axis step: clamp into [0, extent-size], never wrap in either direction.
  function automatic logic [COORD_W-1:0] clamp_step(
    input logic [COORD_W-1:0] pos,
    input logic               du,
    input logic [COORD_W-1:0] extent,
    input logic [COORD_W-1:0] size,
    input logic [COORD_W-1:0] step
  );
    logic [COORD_W-1:0] lim;
    logic [COORD_W:0]   sum;
    lim = (size > extent) ? '0 : extent - size;
    sum = {1'b0, pos} + {1'b0, step};
    if (pos > lim)
      return lim;
    else if (du)
      return (sum > {1'b0, lim}) ? lim : sum[COORD_W-1:0];
    else
      return (pos < step) ? '0 : pos - step;
  endfunction

endpackage

// File: rtl/ball_mover_if.sv
// Request/acknowledge link between the ball mover and the shared VGA plotter.
interface ball_mover_if;
  import ball_pkg::*;

  logic               plot_req;
  logic               plot_ack;
  logic               plot_erase;
  logic [COORD_W-1:0] plot_x;
  logic [COORD_W-1:0] plot_y;

  modport master (
    output plot_req, plot_erase, plot_x, plot_y,
    input  plot_ack
  );

  modport slave (
    input  plot_req, plot_erase, plot_x, plot_y,
    output plot_ack
  );
endinterface

// File: rtl/ball_mover_tick_divider.sv
// Frame-rate divider: single-cycle tick each time the counter wraps; frozen while disabled.
module tick_divider #(
  parameter int FRAME_TICKS = 833333
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!resetn)
      cnt_reg <= '0;
    else if (enable)
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CNT_W'(1);
  end

  assign tick = enable && (cnt_reg == LAST);
endmodule

// File: rtl/ball_mover.sv
// Ball position engine: steps x/y once per frame tick and runs erase/move/draw
// through the plotter handshake.
module ball_mover
  import ball_pkg::*;
#(
  parameter int FRAME_TICKS = 833333,
  parameter int X_INIT      = 76,
  parameter int Y_INIT      = 56,
  parameter int STEP        = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               x_du,
  input  logic               y_du,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_max,
  input  logic [COORD_W-1:0] size,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  ball_mover_if.master       plot
);
  logic               tick;
  state_t             state_reg, state_next;
  logic               pending_reg, pending_next;
  logic [COORD_W-1:0] pos_reg  [2];
  logic [COORD_W-1:0] pos_next [2];
  logic [COORD_W-1:0] extent   [2];
  logic               du       [2];

  tick_divider #(.FRAME_TICKS(FRAME_TICKS)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .tick   (tick)
  );

  // Index 0 is the x axis, index 1 the y axis.
  assign extent[0] = x_max;
  assign extent[1] = y_max;
  assign du[0]     = x_du;
  assign du[1]     = y_du;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      assign pos_next[gi] = clamp_step(pos_reg[gi], du[gi], extent[gi], size, COORD_W'(STEP));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
      pos_reg[0]  <= COORD_W'(X_INIT);
      pos_reg[1]  <= COORD_W'(Y_INIT);
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      if (state_reg == MOVE) begin
        pos_reg[0] <= pos_next[0];
        pos_reg[1] <= pos_next[1];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (pending_reg && enable) state_next = ERASE;
      ERASE: if (plot.plot_ack)         state_next = MOVE;
      MOVE:                             state_next = DRAW;
      DRAW:  if (plot.plot_ack)         state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
    // A tick arriving on the very cycle the FSM starts a step is kept for the next one.
    pending_next = pending_reg;
    if (state_reg == IDLE && state_next != IDLE)
      pending_next = 1'b0;
    if (tick)
      pending_next = 1'b1;
  end

  always_comb begin
    plot.plot_req   = 1'b0;
    plot.plot_erase = 1'b0;
    plot.plot_x     = '0;
    plot.plot_y     = '0;
    unique case (state_reg)
      ERASE: begin
        plot.plot_req   = 1'b1;
        plot.plot_erase = 1'b1;
        plot.plot_x     = pos_reg[0];
        plot.plot_y     = pos_reg[1];
      end
      DRAW: begin
        plot.plot_req   = 1'b1;
        plot.plot_x     = pos_reg[0];
        plot.plot_y     = pos_reg[1];
      end
      default: ;
    endcase
  end

  assign x = pos_reg[0];
  assign y = pos_reg[1];
endmodule

// File: tb/tb_ball_mover.sv
// Directed bench for ball_mover with FRAME_TICKS=4 and a hand-driven plotter ack.
module tb_ball_mover;
  import ball_pkg::*;

  logic               clk    = 1'b0;
  logic               resetn = 1'b0;
  logic               enable = 1'b0;
  logic               x_du   = 1'b0;
  logic               y_du   = 1'b0;
  logic [COORD_W-1:0] x_max  = 10'd160;
  logic [COORD_W-1:0] y_max  = 10'd120;
  logic [COORD_W-1:0] size   = 10'd4;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  int checks   = 0;
  int failures = 0;

  ball_mover_if plot();

  ball_mover #(
    .FRAME_TICKS (4),
    .X_INIT      (76),
    .Y_INIT      (56),
    .STEP        (1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .x_du   (x_du),
    .y_du   (y_du),
    .x_max  (x_max),
    .y_max  (y_max),
    .size   (size),
    .x      (x),
    .y      (y),
    .plot   (plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Counts negedges until plot_req is seen high; a missing request is a failure.
  task automatic wait_req(output int cycles);
    cycles = 0;
    while (plot.plot_req !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    if (plot.plot_req !== 1'b1)
      check("req_timeout", 32'(plot.plot_req), 32'd1);
  endtask

  task automatic handshake(input logic erase, input logic [9:0] ex, input logic [9:0] ey,
                           input int delay);
    int c;
    bit stable;
    wait_req(c);
    $display("txn %s at (%0d,%0d) expect (%0d,%0d) ack_delay=%0d",
             erase ? "erase" : "draw ", plot.plot_x, plot.plot_y, ex, ey, delay);
    check(erase ? "erase_flag" : "draw_flag", 32'(plot.plot_erase), 32'(erase));
    check(erase ? "erase_x" : "draw_x", 32'(plot.plot_x), 32'(ex));
    check(erase ? "erase_y" : "draw_y", 32'(plot.plot_y), 32'(ey));
    stable = 1'b1;
    repeat (delay) begin
      @(negedge clk);
      if (plot.plot_req !== 1'b1 || plot.plot_x !== ex || plot.plot_y !== ey)
        stable = 1'b0;
    end
    if (delay > 0)
      check("req_stable", 32'(stable), 32'd1);
    plot.plot_ack = 1'b1;
    @(negedge clk);
    plot.plot_ack = 1'b0;
  endtask

  task automatic step(input logic [9:0] ox, input logic [9:0] oy,
                      input logic [9:0] nx, input logic [9:0] ny, input int delay);
    handshake(1'b1, ox, oy, delay);
    handshake(1'b0, nx, ny, delay);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit quiet;
    logic [9:0] ox, oy, nx, ny;

    plot.plot_ack = 1'b0;
    resetn = 1'b0;
    enable = 1'b1;
    x_du   = 1'b1;
    y_du   = 1'b0;

    // Reset state and release latency
    @(negedge clk);
    @(negedge clk);
    check("rst_x", 32'(x), 32'd76);
    check("rst_y", 32'(y), 32'd56);
    check("rst_req", 32'(plot.plot_req), 32'd0);
    check("rst_erase", 32'(plot.plot_erase), 32'd0);
    check("rst_plot_x", 32'(plot.plot_x), 32'd0);
    resetn = 1'b1;
    wait_req(c);
    check("first_req_latency", 32'(c), 32'd5);

    // First step, ack one cycle after the request
    $display("txn erase at (%0d,%0d) expect (76,56) ack_delay=1", plot.plot_x, plot.plot_y);
    check("step_erase_flag", 32'(plot.plot_erase), 32'd1);
    check("step_erase_x", 32'(plot.plot_x), 32'd76);
    check("step_erase_y", 32'(plot.plot_y), 32'd56);
    @(negedge clk);
    plot.plot_ack = 1'b1;
    @(negedge clk);
    plot.plot_ack = 1'b0;
    check("move_req_low", 32'(plot.plot_req), 32'd0);
    check("move_x_held", 32'(x), 32'd76);
    @(negedge clk);
    check("x_after_ack", 32'(x), 32'd77);
    check("y_after_ack", 32'(y), 32'd55);
    handshake(1'b0, 10'd77, 10'd55, 1);

    // Run right/up into the clamps: x stops at 160-4, y stops at 0
    ox = 10'd77;
    oy = 10'd55;
    for (int i = 0; i < 84; i++) begin
      nx = (ox < 10'd156) ? ox + 10'd1 : 10'd156;
      ny = (oy > 10'd0) ? oy - 10'd1 : 10'd0;
      step(ox, oy, nx, ny, 0);
      ox = nx;
      oy = ny;
    end
    check("clamp_x_max", 32'(x), 32'd156);
    check("clamp_y_zero", 32'(y), 32'd0);

    // Reverse: x down to 0, y up to 120-4
    x_du = 1'b0;
    y_du = 1'b1;
    for (int i = 0; i < 160; i++) begin
      nx = (ox > 10'd0) ? ox - 10'd1 : 10'd0;
      ny = (oy < 10'd116) ? oy + 10'd1 : 10'd116;
      step(ox, oy, nx, ny, 0);
      ox = nx;
      oy = ny;
    end
    check("clamp_x_zero", 32'(x), 32'd0);
    check("clamp_y_max", 32'(y), 32'd116);

    // Shrunken field: size > x_max pins x at 0, y snaps down to 100-4
    x_du  = 1'b1;
    x_max = 10'd2;
    y_max = 10'd100;
    step(10'd0, 10'd116, 10'd0, 10'd96, 0);
    x_max = 10'd160;
    y_max = 10'd120;

    // Fresh reset for a known tick phase, then an ack stall
    y_du   = 1'b1;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst2_x", 32'(x), 32'd76);
    check("rst2_y", 32'(y), 32'd56);
    resetn = 1'b1;
    wait_req(c);
    check("second_req_latency", 32'(c), 32'd5);
    handshake(1'b1, 10'd76, 10'd56, 20);
    handshake(1'b0, 10'd77, 10'd57, 0);
    wait_req(c);
    check("pending_step_gap", 32'(c), 32'd1);
    enable = 1'b0;
    step(10'd77, 10'd57, 10'd78, 10'd58, 0);

    // Disabled: nothing further may start, counter stays frozen
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (plot.plot_req !== 1'b0)
        quiet = 1'b0;
    end
    check("no_req_disabled", 32'(quiet), 32'd1);
    check("disabled_x", 32'(x), 32'd78);
    enable = 1'b1;
    wait_req(c);
    check("reenable_latency", 32'(c), 32'd4);
    step(10'd78, 10'd58, 10'd79, 10'd59, 0);

    // Reset in the middle of an erase request
    wait_req(c);
    check("mid_erase_flag", 32'(plot.plot_erase), 32'd1);
    check("mid_erase_x", 32'(plot.plot_x), 32'd79);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 32'(plot.plot_req), 32'd0);
    check("mid_rst_x", 32'(x), 32'd76);
    check("mid_rst_y", 32'(y), 32'd56);
    check("mid_rst_plot_x", 32'(plot.plot_x), 32'd0);
    resetn = 1'b1;
    wait_req(c);
    check("post_mid_rst_latency", 32'(c), 32'd5);
    step(10'd76, 10'd56, 10'd77, 10'd57, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
